mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle Moore/Mealy control unit that sequences the shared 32-bit ALU, register file, IR and unified memory port of the multi-cycle MIPS core. Each instruction is stepped through FETCH → DECODE → execute → memory/write-back states. The unit drives the ALU operand selects, the 3-bit ALU op and all write strobes. It stalls on a memory ready handshake.

## Interface
Parameters:
- none. All encodings are fixed in `mc_ctrl_pkg`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_we` out 1: PC write.
- `pc_src` out 2: PC source. 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `ir_we` out 1: IR write.
- `mem_rd` out 1: memory read.
- `mem_we` out 1: memory write.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `reg_we` out 1: register write.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back source. 0 = ALUOut, 1 = MDR.
- `alu_a_sel` out 2: ALU A operand. 0 = PC, 1 = rs reg, 2 = rt reg.
- `alu_b_sel` out 2: ALU B operand. 0 = rt reg, 1 = const 4, 2 = ext imm, 3 = ext imm<<2.
- `ext_op` out 2: extender mode. 00 = zero-ext imm16, 01 = sign-ext imm16, 10 = zero-ext shamt IR[10:6].
- `ALUctr` out 3: ALU op. 000 add, 001 sub, 010 or, 011 and, 100 slt (signed), 101 sra.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse on an unsupported opcode/funct.
- `state` out 4: current state, for debug.

## Operation
- States (4-bit): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, ALU_WB 7, EXEC_I 8, BRANCH 9, JUMP 10. Codes 11–15 go to FETCH.
- Defaults in every state: all strobes 0, selects 0, `ALUctr`=000, `ext_op`=01.
- FETCH:
  - `mem_rd`=1, `iord`=0, A=PC, B=4, add.
  - When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, go to DECODE. Otherwise hold.
- DECODE: A=PC, B=imm<<2, sign-ext, add (branch target into ALUOut).
  - opcode 000000 with legal funct → EXEC_R.
  - 100011 lw / 101011 sw → MEM_ADDR.
  - 001001 addiu / 001101 ori / 001010 slti → EXEC_I.
  - 000100 beq → BRANCH.
  - 000010 j → JUMP.
  - Anything else: `illegal`=1 for this cycle, go to FETCH, no retire pulse.
- Legal funct codes:
  - 100000/100001 → add.
  - 100010/100011 → sub.
  - 100100 → and.
  - 100101 → or.
  - 101010 → slt.
  - 000011 → sra.
- MEM_ADDR: A=rs, B=imm, sign-ext, add. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: `mem_rd`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1, go to FETCH.
- MEM_WRITE: `mem_we`=1, `iord`=1. Hold until `mem_ready`; on that cycle `instr_done`=1, go to FETCH.
- EXEC_R: `ALUctr` from funct, then ALU_WB.
  - Non-sra: A=rs, B=rt.
  - sra: A=rt, B=ext imm with `ext_op`=10.
- EXEC_I: A=rs, B=imm, then ALU_WB.
  - addiu: add, sign-ext.
  - ori: or, zero-ext.
  - slti: slt, sign-ext.
- ALU_WB: `reg_we`=1, `reg_dst`=(opcode==0), `mem_to_reg`=0, `instr_done`=1, go to FETCH.
- BRANCH: A=rs, B=rt, sub. `pc_src`=1, `pc_we`=`zero`, `instr_done`=1, go to FETCH.
- JUMP: `pc_src`=2, `pc_we`=1, `instr_done`=1, go to FETCH.

## Timing
- Reset:
  - While `rst_n`=0: `state`=FETCH, and all strobes (`pc_we`, `ir_we`, `mem_rd`, `mem_we`, `reg_we`, `instr_done`, `illegal`) are forced to 0.
  - Selects take FETCH values.
  - Reset asserted mid-instruction aborts it with no further writes.
- Latency, with zero wait states and counting `mem_ready`=1 cycles:
  - lw 5 cycles.
  - sw, R-type, I-type 4 cycles.
  - beq, j 3 cycles.
  - Each `mem_ready`=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `pc_we`, `ir_we`, `mem_we` completion and `instr_done` in MEM_WRITE are Mealy on `mem_ready` / `zero`. All other outputs are pure functions of state and IR fields.
- A write strobe is never asserted for more than one cycle per instruction.

## Structure
- `mc_ctrl_pkg` holds:
  - state encodings;
  - `pc_src`, `alu_a_sel`, `alu_b_sel` and `ext_op` encodings;
  - opcode and funct constants;
  - `ALUctr` codes.
- Sub-module `mc_alu_decode` (combinational): inputs opcode and funct; outputs `ALUctr`, `ext_op`, `a_is_rt`, `legal`.
- The top level holds the state register, next-state logic and output logic.

## Test plan
- addu ($3=$1+$2, funct 100001), `mem_ready` always 1 → states 0,1,6,7. In EXEC_R `ALUctr`=000. In ALU_WB `reg_we`=1, `reg_dst`=1, `instr_done`=1.
- lw with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total. `mem_rd`=`iord`=1 for 3 cycles. MEM_WB has `mem_to_reg`=1, `reg_dst`=0.
- beq with `zero`=1, then beq with `zero`=0 → in BRANCH, `pc_we` is 1 then 0, with `pc_src`=1 both times. Both take 3 cycles.
- sra (funct 000011) → EXEC_R has `alu_a_sel`=2, `alu_b_sel`=2, `ext_op`=10, `ALUctr`=101. ori → EXEC_I has `ext_op`=00, `ALUctr`=010.
- opcode 111111, then R-type funct 001000 → each gives `illegal`=1 for one cycle in DECODE, returns to FETCH, and produces no `instr_done` and no `reg_we`.
- `rst_n` dropped during MEM_WRITE with `mem_ready`=0 → next state FETCH, `mem_we` goes 0 immediately. After release, the first cycle shows `mem_rd`=1 and `ir_we` only when `mem_ready`=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM state codes,
// datapath select encodings, opcode/funct constants and ALU operation codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_EXEC_I    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10
  } state_t;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // ALU A operand select
  localparam logic [1:0] A_SEL_PC = 2'd0;
  localparam logic [1:0] A_SEL_RS = 2'd1;
  localparam logic [1:0] A_SEL_RT = 2'd2;

  // ALU B operand select
  localparam logic [1:0] B_SEL_RT      = 2'd0;
  localparam logic [1:0] B_SEL_FOUR    = 2'd1;
  localparam logic [1:0] B_SEL_IMM     = 2'd2;
  localparam logic [1:0] B_SEL_IMM_SH2 = 2'd3;

  // Extender modes
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_SHAMT = 2'b10;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational instruction classifier: picks the ALU operation and extender
// mode used in the execute step, flags sra (which takes its A operand from rt)
// and reports whether the opcode/funct pair is supported at all.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctr,
  output logic [1:0] ext_op,
  output logic       a_is_rt,
  output logic       legal
);

  // Opcode/funct lookup; memory, branch and jump opcodes keep the add/sign-ext defaults
  always_comb begin
    alu_ctr = ALU_ADD;
    ext_op  = EXT_SIGN;
    a_is_rt = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_ctr = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctr = ALU_SUB;
          FN_AND:          alu_ctr = ALU_AND;
          FN_OR:           alu_ctr = ALU_OR;
          FN_SLT:          alu_ctr = ALU_SLT;
          FN_SRA: begin
            alu_ctr = ALU_SRA;
            ext_op  = EXT_SHAMT;
            a_is_rt = 1'b1;
          end
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDIU: alu_ctr = ALU_ADD;
      OP_ORI: begin
        alu_ctr = ALU_OR;
        ext_op  = EXT_ZERO;
      end
      OP_SLTI: alu_ctr = ALU_SLT;
      OP_LW, OP_SW, OP_BEQ, OP_J: alu_ctr = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM. Steps each instruction through fetch, decode,
// execute and memory/write-back states, stalling on the memory ready handshake.
// All write strobes are masked while reset is held so an aborted instruction
// cannot write anything.
module mc_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       iord,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] ext_op,
  output logic [2:0] ALUctr,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  // Kept as a raw 4-bit vector so unused codes 11..15 are representable and recover to FETCH
  logic [3:0] state_reg;
  logic [3:0] state_next;

  logic [2:0] dec_alu_ctr;
  logic [1:0] dec_ext_op;
  logic       dec_a_is_rt;
  logic       dec_legal;

  mc_alu_decode u_alu_decode (
    .opcode  (opcode),
    .funct   (funct),
    .alu_ctr (dec_alu_ctr),
    .ext_op  (dec_ext_op),
    .a_is_rt (dec_a_is_rt),
    .legal   (dec_legal)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_FETCH;
    else        state_reg <= state_next;
  end

  assign state = state_reg;

  // Next-state and output decode; strobes forced low while reset is asserted
  always_comb begin
    state_next = state_reg;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_a_sel  = A_SEL_PC;
    alu_b_sel  = B_SEL_RT;
    ext_op     = EXT_SIGN;
    ALUctr     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        mem_rd    = 1'b1;
        alu_b_sel = B_SEL_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target PC + (imm<<2) is computed speculatively into ALUOut
        alu_b_sel = B_SEL_IMM_SH2;
        if (!dec_legal) begin
          illegal    = 1'b1;
          state_next = ST_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:                  state_next = ST_EXEC_R;
            OP_LW, OP_SW:              state_next = ST_MEM_ADDR;
            OP_ADDIU, OP_ORI, OP_SLTI: state_next = ST_EXEC_I;
            OP_BEQ:                    state_next = ST_BRANCH;
            OP_J:                      state_next = ST_JUMP;
            default:                   state_next = ST_FETCH;
          endcase
        end
      end
      ST_MEM_ADDR: begin
        alu_a_sel  = A_SEL_RS;
        alu_b_sel  = B_SEL_IMM;
        state_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        iord = 1'b1;
        if (mem_ready) begin
          mem_we     = 1'b1;
          instr_done = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        // sra shifts rt by the zero-extended shamt field instead of rs op rt
        alu_a_sel  = dec_a_is_rt ? A_SEL_RT : A_SEL_RS;
        alu_b_sel  = dec_a_is_rt ? B_SEL_IMM : B_SEL_RT;
        ext_op     = dec_ext_op;
        ALUctr     = dec_alu_ctr;
        state_next = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_a_sel  = A_SEL_RS;
        alu_b_sel  = B_SEL_IMM;
        ext_op     = dec_ext_op;
        ALUctr     = dec_alu_ctr;
        state_next = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        instr_done = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_a_sel  = A_SEL_RS;
        alu_b_sel  = B_SEL_RT;
        ALUctr     = ALU_SUB;
        pc_src     = PC_SRC_ALUOUT;
        pc_we      = zero;
        instr_done = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase

    if (!rst_n) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_rd     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control. For each instruction the bench derives,
// from the instruction class and the chosen memory wait counts, the expected
// per-cycle state trace and the number of times each strobe must fire, then
// compares the DUT against that.
module tb_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_rd;
  logic       mem_we;
  logic       iord;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [1:0] ext_op;
  logic [2:0] ALUctr;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .iord       (iord),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .ext_op     (ext_op),
    .ALUctr     (ALUctr),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Supported R-type funct codes
  function automatic logic funct_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                      6'b100100, 6'b100101, 6'b101010, 6'b000011};
  endfunction

  // Expected {ALUctr, ext_op, alu_a_sel, alu_b_sel} in the execute cycle
  function automatic logic [8:0] exec_tuple(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b001101) return {3'b010, 2'b00, 2'd1, 2'd2};  // ori
    if (op == 6'b001010) return {3'b100, 2'b01, 2'd1, 2'd2};  // slti
    if (op == 6'b001001) return {3'b000, 2'b01, 2'd1, 2'd2};  // addiu
    case (fn)
      6'b100010, 6'b100011: return {3'b001, 2'b01, 2'd1, 2'd0};
      6'b100100:            return {3'b011, 2'b01, 2'd1, 2'd0};
      6'b100101:            return {3'b010, 2'b01, 2'd1, 2'd0};
      6'b101010:            return {3'b100, 2'b01, 2'd1, 2'd0};
      6'b000011:            return {3'b101, 2'b10, 2'd2, 2'd2};
      default:              return {3'b000, 2'b01, 2'd1, 2'd0};
    endcase
  endfunction

  // Runs one instruction with fw fetch wait cycles and dw data wait cycles
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int dw, input string tag);
    logic [3:0] es[$];
    logic       mr[$];
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_j, legal;
    int c_pcwe = 0, c_irwe = 0, c_mrd = 0, c_mwe = 0, c_rwe = 0;
    int c_done = 0, c_ill = 0, c_iord = 0;
    int e_pcwe, e_mrd, e_rwe, e_iord;
    logic [8:0] got;

    is_r   = (op == 6'b000000);
    is_i   = op inside {6'b001001, 6'b001101, 6'b001010};
    is_lw  = (op == 6'b100011);
    is_sw  = (op == 6'b101011);
    is_beq = (op == 6'b000100);
    is_j   = (op == 6'b000010);
    legal  = is_r ? funct_ok(fn) : (is_i | is_lw | is_sw | is_beq | is_j);

    for (int k = 0; k < fw; k++) begin es.push_back(4'd0); mr.push_back(1'b0); end
    es.push_back(4'd0); mr.push_back(1'b1);
    es.push_back(4'd1); mr.push_back(1'($urandom));
    if (legal) begin
      if (is_r || is_i) begin
        es.push_back(is_r ? 4'd6 : 4'd8); mr.push_back(1'($urandom));
        es.push_back(4'd7);               mr.push_back(1'($urandom));
      end else if (is_lw || is_sw) begin
        es.push_back(4'd2); mr.push_back(1'($urandom));
        for (int k = 0; k < dw; k++) begin es.push_back(is_lw ? 4'd3 : 4'd5); mr.push_back(1'b0); end
        es.push_back(is_lw ? 4'd3 : 4'd5); mr.push_back(1'b1);
        if (is_lw) begin es.push_back(4'd4); mr.push_back(1'($urandom)); end
      end else if (is_beq) begin
        es.push_back(4'd9); mr.push_back(1'($urandom));
      end else begin
        es.push_back(4'd10); mr.push_back(1'($urandom));
      end
    end

    foreach (es[i]) begin
      @(negedge clk);
      opcode    = op;
      funct     = fn;
      mem_ready = mr[i];
      zero      = (es[i] == 4'd9) ? z : 1'($urandom);
      #1;
      tests++;
      if (state !== es[i]) begin
        fails++;
        $display("FAIL %s state cycle %0d: got %0d expected %0d", tag, i, state, es[i]);
      end
      c_pcwe += int'(pc_we);  c_irwe += int'(ir_we);  c_mrd += int'(mem_rd);
      c_mwe  += int'(mem_we); c_rwe  += int'(reg_we); c_done += int'(instr_done);
      c_ill  += int'(illegal); c_iord += int'(iord);
      got = {ALUctr, ext_op, alu_a_sel, alu_b_sel};
      if (es[i] == 4'd1) begin
        tests++;
        if (got !== {3'b000, 2'b01, 2'd0, 2'd3}) begin
          fails++;
          $display("FAIL %s decode alu: got %b expected %b", tag, got, {3'b000, 2'b01, 2'd0, 2'd3});
        end
      end
      if (es[i] == 4'd6 || es[i] == 4'd8) begin
        tests++;
        if (got !== exec_tuple(op, fn)) begin
          fails++;
          $display("FAIL %s exec alu: got %b expected %b", tag, got, exec_tuple(op, fn));
        end
      end
      if (es[i] == 4'd9) begin
        tests++;
        if ({pc_src, ALUctr, pc_we} !== {2'd1, 3'b001, z}) begin
          fails++;
          $display("FAIL %s branch: got pc_src=%0d alu=%b pc_we=%b expected 1 001 %b",
                   tag, pc_src, ALUctr, pc_we, z);
        end
      end
      if (es[i] == 4'd10) begin
        tests++;
        if (pc_src !== 2'd2) begin
          fails++;
          $display("FAIL %s jump pc_src: got %0d expected 2", tag, pc_src);
        end
      end
      if (reg_we === 1'b1) begin
        tests++;
        if ({reg_dst, mem_to_reg} !== (is_lw ? 2'b01 : {is_r, 1'b0})) begin
          fails++;
          $display("FAIL %s writeback sel: got dst=%b m2r=%b expected %b",
                   tag, reg_dst, mem_to_reg, (is_lw ? 2'b01 : {is_r, 1'b0}));
        end
      end
    end

    e_pcwe = 1 + ((is_beq && z) ? 1 : 0) + (is_j && legal ? 1 : 0);
    e_mrd  = fw + 1 + (is_lw ? dw + 1 : 0);
    e_rwe  = (legal && (is_r || is_i || is_lw)) ? 1 : 0;
    e_iord = (is_lw || is_sw) ? dw + 1 : 0;
    tests++;
    if (c_pcwe !== e_pcwe || c_irwe !== 1 || c_mrd !== e_mrd || c_rwe !== e_rwe) begin
      fails++;
      $display("FAIL %s counts pc_we/ir_we/mem_rd/reg_we: got %0d/%0d/%0d/%0d expected %0d/1/%0d/%0d",
               tag, c_pcwe, c_irwe, c_mrd, c_rwe, e_pcwe, e_mrd, e_rwe);
    end
    tests++;
    if (c_mwe !== int'(is_sw) || c_done !== int'(legal) || c_ill !== int'(!legal) || c_iord !== e_iord) begin
      fails++;
      $display("FAIL %s counts mem_we/done/illegal/iord: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               tag, c_mwe, c_done, c_ill, c_iord, int'(is_sw), int'(legal), int'(!legal), e_iord);
    end
    $display("[TB] %s op=%b funct=%b fw=%0d dw=%0d cycles=%0d", tag, op, fn, fw, dw, es.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({state, pc_we, ir_we, mem_rd, mem_we, reg_we, instr_done, illegal} !== {4'd0, 7'b0}) begin
      fails++;
      $display("FAIL reset outputs: got state=%0d strobes=%b expected 0 0000000", state,
               {pc_we, ir_we, mem_rd, mem_we, reg_we, instr_done, illegal});
    end
    tests++;
    if ({iord, alu_a_sel, alu_b_sel, ALUctr} !== {1'b0, 2'd0, 2'd1, 3'b000}) begin
      fails++;
      $display("FAIL reset selects: got %b expected %b", {iord, alu_a_sel, alu_b_sel, ALUctr},
               {1'b0, 2'd0, 2'd1, 3'b000});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_addu();      run_instr(6'b000000, 6'b100001, 1'b0, 0, 0, "addu"); endtask
  task automatic test_lw_stall();  run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, "lw_stall"); endtask
  task automatic test_sw();        run_instr(6'b101011, 6'b000000, 1'b0, 1, 1, "sw"); endtask
  task automatic test_beq();
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not_taken");
  endtask
  task automatic test_sra_ori();
    run_instr(6'b000000, 6'b000011, 1'b0, 0, 0, "sra");
    run_instr(6'b001101, 6'b000000, 1'b0, 0, 0, "ori");
  endtask
  task automatic test_jump();      run_instr(6'b000010, 6'b000000, 1'b0, 2, 0, "j"); endtask
  task automatic test_illegal();
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal_op");
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, "illegal_funct");
  endtask

  task automatic test_random();
    logic [11:0] pool[16];
    logic [11:0] pick;
    pool[0]  = {6'b000000, 6'b100000}; pool[1]  = {6'b000000, 6'b100011};
    pool[2]  = {6'b000000, 6'b100100}; pool[3]  = {6'b000000, 6'b100101};
    pool[4]  = {6'b000000, 6'b101010}; pool[5]  = {6'b000000, 6'b000011};
    pool[6]  = {6'b100011, 6'b010101}; pool[7]  = {6'b101011, 6'b111000};
    pool[8]  = {6'b001001, 6'b000000}; pool[9]  = {6'b001101, 6'b100000};
    pool[10] = {6'b001010, 6'b000011}; pool[11] = {6'b000100, 6'b000000};
    pool[12] = {6'b000010, 6'b101010}; pool[13] = {6'b000000, 6'b000010};
    pool[14] = {6'b001000, 6'b000000}; pool[15] = {6'b000000, 6'b100010};
    for (int n = 0; n < 40; n++) begin
      pick = pool[$urandom_range(0, 15)];
      run_instr(pick[11:6], pick[5:0], 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_write();
    opcode = 6'b101011; funct = 6'b0;
    @(negedge clk); mem_ready = 1'b1;   // FETCH
    @(negedge clk); mem_ready = 1'b0;   // DECODE
    @(negedge clk);                     // MEM_ADDR
    @(negedge clk); #1;                 // MEM_WRITE, stalled
    tests++;
    if (state !== 4'd5) begin
      fails++;
      $display("FAIL midreset setup state: got %0d expected 5", state);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({state, mem_we, mem_rd, ir_we, instr_done} !== {4'd0, 4'b0000}) begin
      fails++;
      $display("FAIL midreset abort: got state=%0d mem_we=%b mem_rd=%b ir_we=%b done=%b expected 0 0 0 0 0",
               state, mem_we, mem_rd, ir_we, instr_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({state, mem_rd, ir_we, pc_we} !== {4'd0, 3'b100}) begin
      fails++;
      $display("FAIL midreset release: got state=%0d mem_rd=%b ir_we=%b pc_we=%b expected 0 1 0 0",
               state, mem_rd, ir_we, pc_we);
    end
    mem_ready = 1'b1;
    #1;
    tests++;
    if ({ir_we, pc_we} !== 2'b11) begin
      fails++;
      $display("FAIL midreset fetch: got ir_we=%b pc_we=%b expected 1 1", ir_we, pc_we);
    end
    $display("[TB] reset_mid_write done");
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_stall();
    test_sw();
    test_beq();
    test_sra_ori();
    test_jump();
    test_illegal();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
